// File: rtl/seq_mul_ctrl.sv
// Sequential shift-add unsigned multiplier: WIDTH iterations per product,
// low half of a*b on out with an overflow flag for a nonzero high half.
module seq_mul_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             overflow
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     sum_c;
    logic [WIDTH-1:0]   addend_c;
    logic               last_c;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign last_c = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_c) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Single WIDTH-wide adder on the upper half; shifting the accumulator right
    // each step is equivalent to adding mcand << i into a fixed accumulator.
    assign addend_c = mplier_q[cnt_q] ? mcand_q : '0;
    assign sum_c    = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, addend_c};

    // Datapath and output next values
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        ovf_d    = ovf_q;
        busy_d   = (state_q == S_RUN);
        done_d   = (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_RUN: begin
                acc_d = {sum_c, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_DONE: begin
                out_d = acc_q[WIDTH-1:0];
                ovf_d = |acc_q[ACC_W-1:WIDTH];
            end
            default: ;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign out      = out_q;
    assign overflow = ovf_q;

endmodule
